rv32i_fetch_unit: RTL and testbench
===================================

// Module: rv32i_fetch_unit
// PURPOSE
//  Instruction fetch stage that feeds the single-cycle RV32I core in place of its direct inst_mem lookup.
//  Issues word fetches to instruction memory over a valid/ready request channel with in-order responses.
//  Buffers returned words, tagged with their PC, in a prefetch FIFO. Offers them to decode via valid/ready.
//  Redirects (taken branch, JAL, JALR) flush the buffer and drop any in-flight responses.
// PARAMETERS
//  RESET_PC    32'h0  first fetch address after reset
//  FIFO_DEPTH  4      prefetch entries; also the maximum number of outstanding requests (power of 2, >=2)
// PORTS
//  clk             in   1   single clock, all state on rising edge
//  reset           in   1   asynchronous, active-high
//  imem_req_valid  out  1   fetch request valid
//  imem_req_ready  in   1   memory accepts request this cycle
//  imem_req_addr   out  32  word-aligned fetch address, [1:0]==0
//  imem_rsp_valid  in   1   response word valid; in request order; never back-pressured
//  imem_rsp_data   in   32  instruction word
//  redirect_valid  in   1   core requests a PC change (single-cycle pulse)
//  redirect_pc     in   32  target; [1:0] ignored, forced to 0
//  inst_valid      out  1   inst_data/inst_pc valid to decode
//  inst_ready      in   1   decode consumes the head entry
//  inst_data       out  32  instruction word
//  inst_pc         out  32  PC of inst_data
// BEHAVIOUR
//  Reset: imem_req_valid=0, inst_valid=0, inst_data=0, inst_pc=0, FIFO empty, outstanding=0, discard=0.
//   fetch_pc=RESET_PC, rsp_pc=RESET_PC. imem_req_valid rises in the first cycle after reset deasserts.
//  Credits: imem_req_valid = (fifo_count + outstanding) < FIFO_DEPTH.
//   Every accepted response is therefore guaranteed a FIFO slot.
//  Request accepted when valid&&ready: outstanding+=1, fetch_pc+=4.
//   fetch_pc wraps modulo 2^32 (32'hFFFFFFFC -> 0).
//  Request hold: imem_req_addr is stable while imem_req_valid=1 and ready=0.
//   The only exception is a redirect, which may withdraw or retarget a pending request.
//  Response: outstanding-=1 on each response.
//   If discard>0: the word is dropped and discard-=1.
//   Otherwise: push {rsp_pc, data} and rsp_pc+=4.
//   Accept and response in the same cycle: outstanding unchanged.
//  Output: inst_valid = FIFO non-empty; inst_data/inst_pc = head entry.
//   Pop on inst_valid&&inst_ready. Response at cycle N is visible at earliest in cycle N+1 (registered FIFO).
//   Push and pop in the same cycle when full: legal; the credit rule keeps count <= FIFO_DEPTH.
//  Redirect (highest priority), taking effect at the clock edge:
//   - FIFO cleared. inst_ready ignored in the redirect cycle; the head is NOT counted as consumed.
//   - fetch_pc and rsp_pc <= {redirect_pc[31:2],2'b00}.
//   - discard <= outstanding_next: every request accepted up to and including the redirect cycle is dropped.
//   - A response arriving in the redirect cycle is dropped and decrements the outstanding count.
//   - inst_valid=0 in the cycle after a redirect.
//  Back-to-back redirects: the latest target wins; discard recomputed each time.
//  Counter widths: $clog2(FIFO_DEPTH+1). outstanding and discard never exceed FIFO_DEPTH;
//   a response with outstanding==0 is a protocol error and asserts in simulation.
//  Reset mid-operation: immediate return to the reset state. In-flight responses after reset are the
//   memory's responsibility (memory shares the same reset).
// STRUCTURE
//  rv32i_pkg: XLEN=32, ILEN=32, PC_STEP=4, RESET_VECTOR default, NOP encoding 32'h00000013.
//  Sub-module rv32i_fetch_fifo: synchronous FIFO, width 64 ({pc,inst}), depth FIFO_DEPTH.
//   Provides flush, count and full/empty signals.
//  Top level: fetch_pc, rsp_pc, outstanding and discard counters, credit logic, redirect priority.
// TESTING
//  1 Reset then memory ready=1 with 1-cycle latency, decode ready=1:
//    inst_pc sequence 0,4,8,12 with inst_data matching memory contents; no gaps after warm-up.
//  2 Decode ready=0 for 10 cycles: exactly 4 requests issued, then imem_req_valid=0.
//    On release, 4 words pop in order and no word is lost.
//  3 Memory latency 3, redirect to 32'h100 while 3 requests are outstanding:
//    3 responses dropped, next inst_pc=32'h100, no stale PC ever reaches inst_valid.
//  4 Redirect in the same cycle as a response and inst_ready=1:
//    the response is dropped, head not popped, inst_valid=0 next cycle, then PC=target.
//  5 redirect_pc=32'hFFFFFFFE: fetch addresses 32'hFFFFFFFC, then 32'h0 (wrap). inst_pc follows.
//  6 Assert reset for 1 cycle mid-stream with 2 requests outstanding:
//    outputs 0 during reset, restart from RESET_PC, FIFO empty.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I constants and the fetch-buffer entry type.
// Used by the fetch unit and its prefetch FIFO.
package rv32i_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam logic [XLEN-1:0] PC_STEP      = 32'd4;
    localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;
    localparam logic [ILEN-1:0] NOP_INST     = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } fetch_entry_t;

    // Instruction fetches are always word aligned; low two address bits are dropped.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~(PC_STEP - 32'd1);
    endfunction

endpackage

// File: rtl/rv32i_fetch_fifo.sv
// Prefetch buffer holding {pc, inst} pairs between memory responses and decode.
// Flush empties it in one cycle and overrides any push/pop in that cycle.
module rv32i_fetch_fifo
    import rv32i_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push,
    input  fetch_entry_t                 push_data,
    input  logic                         pop,
    output fetch_entry_t                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count_q;

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/rv32i_fetch_unit.sv
// Credit-based instruction fetch stage: issues word fetches, buffers responses
// tagged with their PC, and drops in-flight words after a redirect.
module rv32i_fetch_unit
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_VECTOR,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] CREDIT_LIMIT = (CW+1)'(FIFO_DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic [31:0]   target_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_next;
    logic [CW-1:0] discard;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   credit_used;
    logic          fifo_full;
    logic          fifo_empty;
    logic          req_fire;
    logic          rsp_keep;
    logic          pop;
    fetch_entry_t  push_entry;
    fetch_entry_t  head;

    // Every issued request owns a FIFO slot until its word is consumed or dropped.
    assign credit_used    = {1'b0, fifo_count} + {1'b0, outstanding};
    assign imem_req_valid = !reset && (credit_used < CREDIT_LIMIT);
    assign imem_req_addr  = fetch_pc;

    assign req_fire         = imem_req_valid && imem_req_ready;
    assign rsp_keep         = imem_rsp_valid && (discard == '0) && !redirect_valid;
    assign pop              = inst_valid && inst_ready && !redirect_valid;
    assign outstanding_next = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
    assign target_pc        = align_pc(redirect_pc);
    assign push_entry       = '{pc: rsp_pc, inst: imem_rsp_data};

    // A redirect discards everything still in flight, including a request accepted this cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect_valid) begin
                fetch_pc <= target_pc;
                rsp_pc   <= target_pc;
                discard  <= outstanding_next;
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + PC_STEP;
                if (rsp_keep) rsp_pc   <= rsp_pc + PC_STEP;
                if (imem_rsp_valid && (discard != '0)) discard <= discard - CW'(1);
            end
        end
    end

    rv32i_fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (redirect_valid),
        .push     (rsp_keep),
        .push_data(push_entry),
        .pop      (pop),
        .head     (head),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign inst_valid = !fifo_empty;
    assign inst_data  = head.inst;
    assign inst_pc    = head.pc;

    rsp_has_owner: assert property (@(posedge clk) disable iff (reset)
        !(imem_rsp_valid && (outstanding == '0)));

    fifo_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(fifo_full && rsp_keep && !pop));

endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// Directed bench for rv32i_fetch_unit with an in-order, fixed-latency memory model.
module tb_rv32i_fetch_unit;

    logic        clk            = 1'b0;
    logic        reset          = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = 32'h0;
    logic        inst_valid;
    logic        inst_ready     = 1'b1;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    typedef struct packed {
        logic [31:0] addr;
        int          due;
    } memReq_t;

    memReq_t memQueue[$];
    int      memCycle    = 0;
    int      memLatency  = 1;
    int      acceptCount = 0;

    logic    watchStale  = 1'b0;
    int      staleSeen   = 0;

    always #5 clk = ~clk;

    rv32i_fetch_unit #(
        .RESET_PC  (32'h0),
        .FIFO_DEPTH(4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst_data     (inst_data),
        .inst_pc       (inst_pc)
    );

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return addr ^ 32'hA5A5_0013;
    endfunction

    // Memory answers in request order, memLatency cycles after acceptance, and shares reset.
    always @(negedge clk) begin
        memReq_t r;
        #1;
        memCycle++;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        if (reset) begin
            memQueue.delete();
            acceptCount = 0;
        end else begin
            if (memQueue.size() > 0 && memQueue[0].due <= memCycle) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = memWord(memQueue[0].addr);
                void'(memQueue.pop_front());
            end
            if (imem_req_valid && imem_req_ready) begin
                r.addr = imem_req_addr;
                r.due  = memCycle + memLatency;
                memQueue.push_back(r);
                acceptCount++;
            end
        end
    end

    // Anything below the redirect target showing up after the redirect is a stale word.
    always @(posedge clk) begin
        if (watchStale && inst_valid && inst_pc < 32'h100) staleSeen++;
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] expPc);
        checkVal({tag, "_valid"}, {31'b0, inst_valid}, 32'd1);
        checkVal({tag, "_pc"}, inst_pc, expPc);
        checkVal({tag, "_data"}, inst_data, memWord(expPc));
    endtask

    task automatic stepCycle();
        @(negedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic memReady, input logic decReady,
                                 input logic redir, input logic [31:0] redirPc);
        @(negedge clk);
        imem_req_ready = memReady;
        inst_ready     = decReady;
        redirect_valid = redir;
        redirect_pc    = redirPc;
        #2;
    endtask

    task automatic waitInstValid(input string tag);
        int n = 0;
        while (!inst_valid && n < 40) begin
            stepCycle();
            n++;
        end
        checkVal({tag, "_wait"}, {31'b0, inst_valid}, 32'd1);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset          = 1'b1;
        redirect_valid = 1'b0;
        #2;
        stepCycle();
        @(negedge clk);
        reset = 1'b0;
        #2;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkVal({tag, "_req_valid"}, {31'b0, imem_req_valid}, 32'd0);
        checkVal({tag, "_inst_valid"}, {31'b0, inst_valid}, 32'd0);
        checkVal({tag, "_inst_data"}, inst_data, 32'h0);
        checkVal({tag, "_inst_pc"}, inst_pc, 32'h0);
        checkVal({tag, "_req_addr"}, imem_req_addr, 32'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset state
        stepCycle();
        checkResetOutputs("rst");

        // 1: streaming at 1-cycle latency
        @(negedge clk);
        reset = 1'b0;
        #2;
        checkVal("t1_req_valid", {31'b0, imem_req_valid}, 32'd1);
        checkVal("t1_req_addr", imem_req_addr, 32'h0);
        waitInstValid("t1");
        checkOutput("t1_pc0", 32'h0);
        stepCycle();
        checkOutput("t1_pc4", 32'h4);
        stepCycle();
        checkOutput("t1_pc8", 32'h8);
        stepCycle();
        checkOutput("t1_pc12", 32'hC);

        // 2: decode stall fills all credits
        inst_ready = 1'b0;
        doReset();
        repeat (10) stepCycle();
        checkVal("t2_accepts", acceptCount, 32'd4);
        checkVal("t2_req_valid", {31'b0, imem_req_valid}, 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("t2_pop0", 32'h0);
        stepCycle();
        checkOutput("t2_pop4", 32'h4);
        stepCycle();
        checkOutput("t2_pop8", 32'h8);
        stepCycle();
        checkOutput("t2_pop12", 32'hC);
        stepCycle();
        waitInstValid("t2_refill");
        checkOutput("t2_pop16", 32'h10);

        // 3: redirect with three requests in flight at latency 3
        memLatency = 3;
        doReset();
        stepCycle();
        stepCycle();
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h100);
        checkVal("t3_rsp_in_redirect", {31'b0, imem_rsp_valid}, 32'd1);
        checkVal("t3_valid_at_redirect", {31'b0, inst_valid}, 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        watchStale = 1'b1;
        checkVal("t3_valid_after", {31'b0, inst_valid}, 32'd0);
        waitInstValid("t3");
        checkOutput("t3_target", 32'h100);
        stepCycle();
        checkOutput("t3_next", 32'h104);
        watchStale = 1'b0;
        checkVal("t3_stale", staleSeen, 32'd0);

        // 4: redirect colliding with a response while decode is ready
        memLatency = 1;
        doReset();
        waitInstValid("t4_warm");
        stepCycle();
        stepCycle();
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h200);
        checkVal("t4_rsp_same_cycle", {31'b0, imem_rsp_valid}, 32'd1);
        checkVal("t4_head_present", {31'b0, inst_valid}, 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkVal("t4_valid_after", {31'b0, inst_valid}, 32'd0);
        stepCycle();
        checkVal("t4_valid_after2", {31'b0, inst_valid}, 32'd0);
        waitInstValid("t4");
        checkOutput("t4_target", 32'h200);

        // 5: unaligned redirect near the top of the address space wraps to zero
        applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkVal("t5_req_valid", {31'b0, imem_req_valid}, 32'd1);
        checkVal("t5_addr_top", imem_req_addr, 32'hFFFF_FFFC);
        stepCycle();
        checkVal("t5_addr_wrap", imem_req_addr, 32'h0);
        waitInstValid("t5");
        checkOutput("t5_pc_top", 32'hFFFF_FFFC);
        stepCycle();
        checkOutput("t5_pc_wrap", 32'h0);

        // 6: one-cycle reset in the middle of a latency-2 stream
        memLatency = 2;
        repeat (6) stepCycle();
        @(negedge clk);
        reset = 1'b1;
        #2;
        checkResetOutputs("t6_rst");
        stepCycle();
        @(negedge clk);
        reset = 1'b0;
        #2;
        checkVal("t6_empty", {31'b0, inst_valid}, 32'd0);
        checkVal("t6_req_valid", {31'b0, imem_req_valid}, 32'd1);
        checkVal("t6_req_addr", imem_req_addr, 32'h0);
        waitInstValid("t6");
        checkOutput("t6_pc0", 32'h0);
        stepCycle();
        checkOutput("t6_pc4", 32'h4);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
